seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised multiplexed seven-segment display driver, the next generation of the board display path. It scans `DIGITS` common-anode digits from one system clock, with a built-in scan prescaler, frame-synchronous data latching (no tearing), per-digit enable, decimal points, per-digit blinking and optional leading-zero suppression. It sits between the datapath, which presents packed hex nibbles, and the board's `an`/`segs` pins.

## Interface
- `DIGITS`, 8: number of digits scanned, 1..16.
- `CLK_HZ`, 100_000_000: frequency of `CP`.
- `SCAN_HZ`, 1000: digit-advance rate. `DIV = CLK_HZ/SCAN_HZ` must be an integer ≥ 2.
- `BLINK_FRAMES`, 128: frames per blink half-period, ≥ 1.
- `CP`  in  1  system clock; all state is on the rising edge.
- `nCR`  in  1  asynchronous active-low reset.
- `DATA`  in  4*DIGITS  hex nibbles; digit i is `DATA[4i+3:4i]`, and digit 0 is the rightmost.
- `DP`  in  DIGITS  decimal point request per digit, 1 = lit.
- `EN`  in  DIGITS  digit enable, 0 = digit dark.
- `BLINK`  in  DIGITS  1 = digit blinks.
- `LZ_EN`  in  1  1 = suppress leading zeros.
- `an`  out  DIGITS  anode selects, active-low, one-hot-low when lit.
- `segs`  out  7  segments, active-low; `segs[0]`=a … `segs[6]`=g.
- `dot`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse after the last digit of each frame.

## Operation
- **Prescaler:** counter 0..DIV-1, free-running. `tick` is asserted for one cycle when the count is DIV-1.
- **Digit index `idx`:** 0..DIGITS-1. It advances on `tick` and wraps from DIGITS-1 to 0.
- **Shadow registers:** hold `DATA`, `DP`, `EN`, `BLINK` and `LZ_EN`. They load from the inputs only on a `tick` where `idx==DIGITS-1`. Rendering uses only shadow values, so input changes mid-frame never appear until the next frame.
- **Render on each `tick`**, for digit `idx`:
  - `an` = all ones except bit `idx` = 0, provided the digit is visible; otherwise all ones.
  - `segs` = hex decode of the nibble. The encoding is active-low gfedcba:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - `dot` = ~shadow `DP[idx]` when visible, otherwise 1.
- **Visibility:** a digit is visible when all three hold:
  - `EN[idx]`=1;
  - not (blink phase = 1 and `BLINK[idx]`=1);
  - not leading-zero-suppressed.
- **Leading-zero suppression** (only when shadow `LZ_EN`=1): digit i is suppressed if its nibble and every nibble above it (i+1..DIGITS-1) are 0. Digit 0 is never suppressed. `EN` does not affect the zero test.
- **Blink:** a frame counter 0..BLINK_FRAMES-1 increments at each frame end. The blink phase toggles when the counter wraps. Phase resets to 0 (shown).
- **`frame_done`:** asserts in the cycle after the `tick` with `idx==DIGITS-1`.

## Timing
- **Reset values** (async on `nCR`=0, held until release):
  - `an` all ones, `segs`=7'b1111111, `dot`=1, `frame_done`=0;
  - prescaler 0, `idx`=0, all shadows 0, frame counter 0, blink phase 0.
- **First frame after reset:** shadow `EN`=0, so the display stays dark. The first load happens at the end of frame 0, and frame 1 shows the inputs.
- **Register latency:** outputs are registered and change one cycle after `tick`. They hold for exactly DIV cycles per digit, giving DIGITS*DIV cycles per frame.
- **Input-to-display latency:** at most 2 frames; at least 1 frame plus 1 cycle.
- **Same-tick shadow load:** in the `tick` that loads the shadows, digit DIGITS-1 is rendered from the old shadow values.
- **DIGITS=1:** every tick is a frame end; the shadows load every tick.
- **Mid-operation reset:** outputs blank immediately (asynchronously). There is no partial state after release.
- **No tick stretching:** there is no handshake. Inputs may change on any cycle, and only the load cycle samples them.

## Test plan
All scenarios use `DIGITS`=4, `CLK_HZ`=4, `SCAN_HZ`=1 (DIV=4), `BLINK_FRAMES`=2.

- **Reset:** drive `nCR`=0 mid-scan.
  - Outputs go to `an`=1111, `segs`=1111111, `dot`=1 within the same cycle.
  - After release, frame 0 stays dark (16 cycles), with `frame_done` pulsing at cycle 16.
- **Basic scan:** `DATA`=16'h1A3F, `EN`=1111, `DP`=0100.
  - Frame 1 produces, in order:
    - `an`=1110 with `segs`=0001110;
    - `an`=1101 with 0110000;
    - `an`=1011 with 0001000 and `dot`=0;
    - `an`=0111 with 1111001.
  - Each step holds for 4 cycles.
- **Tearing:** change `DATA` to 16'h0000 during digit 1 of frame 1.
  - Frame 1 still shows 1A3F.
  - Frame 2 shows 0000.
- **Leading zeros:** `LZ_EN`=1, `DATA`=16'h0050.
  - Digits 3 and 2 are dark (`an` all ones).
  - Digit 1 shows 5 (0010010); digit 0 shows 0 (1000000).
  - With `DATA`=16'h0000, only digit 0 lights.
- **Blink/enable:** `BLINK`=0001, `EN`=1011.
  - Digit 2 is never lit.
  - Digit 0 is lit for 2 frames, dark for 2 frames, repeating.
  - Digits 1 and 3 are always lit.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed common-anode seven-segment display scanner
//
// Scans DIGITS digits one at a time at SCAN_HZ. Inputs are captured into
// shadow registers once per frame (on the final digit's tick) so a frame is
// always rendered from one consistent snapshot.
//
// Ports:
//   CP          system clock, rising edge
//   nCR         asynchronous active-low reset
//   DATA        packed hex nibbles, digit i = DATA[4i+3:4i], digit 0 rightmost
//   DP          per-digit decimal point request (1 = lit)
//   EN          per-digit enable (0 = dark)
//   BLINK       per-digit blink enable
//   LZ_EN       suppress leading zeros
//   an          anode selects, active-low
//   segs        segments gfedcba, active-low
//   dot         decimal point, active-low
//   frame_done  one-cycle pulse after the last digit of each frame
module seven_seg_scanner #(
  parameter int DIGITS       = 8,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     EN,
  input  logic [DIGITS-1:0]     BLINK,
  input  logic                  LZ_EN,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            segs,
  output logic                  dot,
  output logic                  frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       frame_cnt;
  logic                phase;

  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_en;
  logic [DIGITS-1:0]   sh_blink;
  logic                sh_lz;

  logic                tick;
  logic                frame_end;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   supp;
  logic                all_zero;
  logic                visible;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick      = (presc == PRE_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) nib = sh_data[4*i +: 4];
    end
  end

  // Walk from the most significant digit down; a digit is suppressed while
  // every nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    all_zero = 1'b1;
    supp     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (sh_data[4*i +: 4] == 4'h0);
      if (i != 0) supp[i] = sh_lz & all_zero;
    end
  end

  always_comb begin
    visible = sh_en[idx] & ~(phase & sh_blink[idx]) & ~supp[idx];
    an_next = '1;
    if (visible) an_next[idx] = 1'b0;
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      presc      <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      phase      <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_blink   <= '0;
      sh_lz      <= 1'b0;
      an         <= '1;
      segs       <= 7'b1111111;
      dot        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      presc      <= tick ? '0 : presc + 1'b1;

      if (tick) begin
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        an   <= an_next;
        segs <= hex7(nib);
        dot  <= visible ? ~sh_dp[idx] : 1'b1;
      end

      // Shadows update in the same edge that renders the last digit, so that
      // digit still uses the previous snapshot.
      if (frame_end) begin
        sh_data  <= DATA;
        sh_dp    <= DP;
        sh_en    <= EN;
        sh_blink <= BLINK;
        sh_lz    <= LZ_EN;
        if (frame_cnt == BLK_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        CP = 1'b0;
  logic        nCR;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [3:0]  EN;
  logic [3:0]  BLINK;
  logic        LZ_EN;
  logic [3:0]  an;
  logic [6:0]  segs;
  logic        dot;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int e      = 0;

  seven_seg_scanner #(
    .DIGITS(4),
    .CLK_HZ(4),
    .SCAN_HZ(1),
    .BLINK_FRAMES(2)
  ) dut (
    .CP(CP),
    .nCR(nCR),
    .DATA(DATA),
    .DP(DP),
    .EN(EN),
    .BLINK(BLINK),
    .LZ_EN(LZ_EN),
    .an(an),
    .segs(segs),
    .dot(dot),
    .frame_done(frame_done)
  );

  always #5 CP = ~CP;

  task automatic adv(input int n);
    repeat (n) @(posedge CP);
    @(negedge CP);
    e += n;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_an,
                          input logic [6:0] exp_segs, input logic exp_dot,
                          input bit chk_segs);
    chk({tag, ".an"}, {12'h0, an}, {12'h0, exp_an});
    chk({tag, ".dot"}, {15'h0, dot}, {15'h0, exp_dot});
    if (chk_segs) chk({tag, ".segs"}, {9'h0, segs}, {9'h0, exp_segs});
  endtask

  logic [6:0] seg1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic [5:0] d0_lit = 6'b110010;

  initial begin
    nCR   = 1'b0;
    DATA  = 16'h1A3F;
    EN    = 4'b1111;
    DP    = 4'b0100;
    BLINK = 4'b0000;
    LZ_EN = 1'b0;
    repeat (2) @(negedge CP);
    chk_disp("reset", 4'b1111, 7'b1111111, 1'b1, 1'b1);
    chk("reset.fd", {15'h0, frame_done}, 16'h0);
    nCR = 1'b1;
    e   = 0;

    // Frame 0: dark, frame_done pulse after edge 16
    adv(4);  chk_disp("f0d0", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("f0d1", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("f0d2", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(3);  chk("fd15", {15'h0, frame_done}, 16'h0);
    adv(1);  chk_disp("f0d3", 4'b1111, 7'b0, 1'b1, 1'b0);
             chk("fd16", {15'h0, frame_done}, 16'h1);
    adv(1);  chk("fd17", {15'h0, frame_done}, 16'h0);

    // Frame 1: 1A3F with DP on digit 2; DATA changes mid-frame
    adv(3);  chk_disp("f1d0", 4'b1110, 7'b0001110, 1'b1, 1'b1);
    adv(3);  chk_disp("f1d0hold", 4'b1110, 7'b0001110, 1'b1, 1'b1);
    adv(1);  chk_disp("f1d1", 4'b1101, 7'b0110000, 1'b1, 1'b1);
    DATA = 16'h0000;
    adv(4);  chk_disp("f1d2", 4'b1011, 7'b0001000, 1'b0, 1'b1);
    adv(4);  chk_disp("f1d3", 4'b0111, 7'b1111001, 1'b1, 1'b1);
    adv(4);  chk_disp("f2d0", 4'b1110, 7'b1000000, 1'b1, 1'b1);
    adv(4);  chk_disp("f2d1", 4'b1101, 7'b1000000, 1'b1, 1'b1);

    // Mid-scan reset blanks immediately
    adv(2);
    nCR = 1'b0;
    #1;
    chk_disp("midreset", 4'b1111, 7'b1111111, 1'b1, 1'b1);
    chk("midreset.fd", {15'h0, frame_done}, 16'h0);
    DATA  = 16'h0050;
    LZ_EN = 1'b1;
    DP    = 4'b0000;
    repeat (2) @(negedge CP);
    nCR = 1'b1;
    e   = 0;

    // Leading-zero suppression
    adv(20); chk_disp("lz1d0", 4'b1110, 7'b1000000, 1'b1, 1'b1);
    adv(4);  chk_disp("lz1d1", 4'b1101, 7'b0010010, 1'b1, 1'b1);
    DATA = 16'h0000;
    adv(4);  chk_disp("lz1d2", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("lz1d3", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("lz2d0", 4'b1110, 7'b1000000, 1'b1, 1'b1);
    adv(4);  chk_disp("lz2d1", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("lz2d2", 4'b1111, 7'b0, 1'b1, 1'b0);
    adv(4);  chk_disp("lz2d3", 4'b1111, 7'b0, 1'b1, 1'b0);

    // Blink / enable
    nCR   = 1'b0;
    DATA  = 16'h1234;
    LZ_EN = 1'b0;
    EN    = 4'b1011;
    BLINK = 4'b0001;
    repeat (2) @(negedge CP);
    nCR = 1'b1;
    e   = 0;
    for (int f = 1; f <= 5; f++) begin
      for (int d = 0; d < 4; d++) begin
        logic       lit;
        logic [3:0] exp_an;
        adv(16*f + 4*(d+1) - e);
        case (d)
          0:       lit = d0_lit[f];
          2:       lit = 1'b0;
          default: lit = 1'b1;
        endcase
        exp_an = 4'b1111;
        if (lit) exp_an[d] = 1'b0;
        chk_disp($sformatf("blink_f%0d_d%0d", f, d), exp_an, seg1234[d], 1'b1, lit);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
